// File: rtl/matrix_scan_if.sv
// Bundle between the game controller (master) and the matrix scan controller (slave):
// frame/brightness inputs in, column select and row drives out.
interface matrix_scan_if;
    logic        enable;
    logic [3:0]  brightness;
    logic [23:0] column_0;
    logic [23:0] column_1;
    logic [23:0] column_2;
    logic [23:0] column_3;
    logic [3:0]  col_sel_n;
    logic [7:0]  row_r;
    logic [7:0]  row_g;
    logic [7:0]  row_b;
    logic        frame_start;

    modport master (
        output enable, brightness, column_0, column_1, column_2, column_3,
        input  col_sel_n, row_r, row_g, row_b, frame_start
    );

    modport slave (
        input  enable, brightness, column_0, column_1, column_2, column_3,
        output col_sel_n, row_r, row_g, row_b, frame_start
    );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Time-multiplexed 4-column x 8-row RGB matrix scanner: per-frame snapshot,
// blanking gap before each column and 16-slot brightness PWM within each dwell.
module matrix_scan_ctrl #(
    parameter int unsigned DWELL_CYCLES = 12500,
    parameter int unsigned BLANK_CYCLES = 250
) (
    input  logic           CLK_50M,
    input  logic           RST_N,
    matrix_scan_if.slave   bus
);

    localparam int unsigned SLOT_LEN = DWELL_CYCLES / 16;
    localparam int unsigned CNT_MAX  = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W    = $clog2(CNT_MAX);
    localparam int unsigned SCNT_W   = $clog2(SLOT_LEN + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_BLANK, ST_DRIVE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [SCNT_W-1:0]   slot_cyc_q, slot_cyc_d;
    logic [3:0]          slot_q, slot_d;
    logic [3:0]          bright_q, bright_d;
    logic [3:0][23:0]    shadow_q, shadow_d;
    logic [3:0]          col_sel_n_q, col_sel_n_d;
    logic [7:0]          row_r_q, row_r_d;
    logic [7:0]          row_g_q, row_g_d;
    logic [7:0]          row_b_q, row_b_d;
    logic                frame_start_q, frame_start_d;
    logic [0:7][2:0]     drive_cell;

    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            col_idx_q     <= '0;
            cnt_q         <= '0;
            slot_cyc_q    <= '0;
            slot_q        <= '0;
            bright_q      <= '0;
            shadow_q      <= '0;
            col_sel_n_q   <= 4'hF;
            row_r_q       <= '0;
            row_g_q       <= '0;
            row_b_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            col_idx_q     <= col_idx_d;
            cnt_q         <= cnt_d;
            slot_cyc_q    <= slot_cyc_d;
            slot_q        <= slot_d;
            bright_q      <= bright_d;
            shadow_q      <= shadow_d;
            col_sel_n_q   <= col_sel_n_d;
            row_r_q       <= row_r_d;
            row_g_q       <= row_g_d;
            row_b_q       <= row_b_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Sequencing: IDLE -> LOAD -> BLANK -> DRIVE -> LOAD ...; enable low wins everywhere.
    always_comb begin
        state_d    = state_q;
        col_idx_d  = col_idx_q;
        cnt_d      = cnt_q;
        slot_cyc_d = slot_cyc_q;
        slot_d     = slot_q;
        bright_d   = bright_q;
        shadow_d   = shadow_q;

        if (!bus.enable) begin
            state_d    = ST_IDLE;
            col_idx_d  = '0;
            cnt_d      = '0;
            slot_cyc_d = '0;
            slot_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d   = ST_LOAD;
                    col_idx_d = '0;
                    cnt_d     = '0;
                end
                ST_LOAD: begin
                    bright_d = bus.brightness;
                    if (col_idx_q == 2'd0) begin
                        shadow_d[0] = bus.column_0;
                        shadow_d[1] = bus.column_1;
                        shadow_d[2] = bus.column_2;
                        shadow_d[3] = bus.column_3;
                    end
                    state_d = ST_BLANK;
                    cnt_d   = '0;
                end
                ST_BLANK: begin
                    if (cnt_q == CNT_W'(BLANK_CYCLES - 1)) begin
                        state_d    = ST_DRIVE;
                        cnt_d      = '0;
                        slot_cyc_d = '0;
                        slot_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
                        state_d   = ST_LOAD;
                        col_idx_d = col_idx_q + 2'd1;
                        cnt_d     = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                        // Slot 15 absorbs any remainder when the dwell is not an exact multiple of 16.
                        if (slot_cyc_q == SCNT_W'(SLOT_LEN - 1)) begin
                            slot_cyc_d = '0;
                            if (slot_q != 4'd15) begin
                                slot_d = slot_q + 4'd1;
                            end
                        end else begin
                            slot_cyc_d = slot_cyc_q + SCNT_W'(1);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs are decoded from the next state so the registered pins line up with the state.
    always_comb begin
        col_sel_n_d   = 4'hF;
        row_r_d       = '0;
        row_g_d       = '0;
        row_b_d       = '0;
        frame_start_d = (state_d == ST_LOAD) && (col_idx_d == 2'd0);
        drive_cell    = shadow_d[col_idx_d];

        if (state_d == ST_DRIVE) begin
            col_sel_n_d = ~(4'b0001 << col_idx_d);
            if (slot_d <= bright_d) begin
                for (int n = 0; n < 8; n++) begin
                    row_r_d[3'(n)] = drive_cell[3'(n)][2];
                    row_g_d[3'(n)] = drive_cell[3'(n)][1];
                    row_b_d[3'(n)] = drive_cell[3'(n)][0];
                end
            end
        end
    end

    assign bus.col_sel_n   = col_sel_n_q;
    assign bus.row_r       = row_r_q;
    assign bus.row_g       = row_g_q;
    assign bus.row_b       = row_b_q;
    assign bus.frame_start = frame_start_q;

endmodule
